// File: rtl/conv_result_streamer_pkg.sv
// conv_result_streamer_pkg: shared state encoding, result-entry layout and saturation limits
//   state_t       : output FSM states (IDLE=0, VALID=1)
//   RESULT_BITS   : default result word width
//   entry_w()     : width of a stored {last, data} entry
//   sat_max/min() : signed clamp limits for a given word width
package conv_result_streamer_pkg;
   typedef enum logic {IDLE = 1'b0, VALID = 1'b1} state_t;
   localparam int RESULT_BITS = 16;
   typedef struct packed {
      logic                   last;
      logic [RESULT_BITS-1:0] data;
   } result_entry_t;
   function automatic int entry_w(int bl);
      return bl + 1;
   endfunction
   function automatic logic [63:0] sat_max(int bl);
      return (64'd1 << (bl - 1)) - 64'd1;
   endfunction
   function automatic logic [63:0] sat_min(int bl);
      return 64'd1 << (bl - 1);
   endfunction
endpackage

// File: rtl/conv_result_streamer_fifo.sv
// result_sync_fifo: single-clock FIFO with registered occupancy
//   clk, rst_n     : clock, async active-low reset
//   push/din       : write request and entry (ignored when full)
//   pop/dout       : read request and current head (ignored when empty)
//   empty/full     : occupancy flags derived from level
//   level          : number of stored entries
module result_sync_fifo #(
   parameter int W     = 17,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign empty   = level == '0;
   assign full    = level == (AW+1)'(DEPTH);
   assign dout    = mem[rd_ptr];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/conv_result_streamer.sv
// conv_result_streamer: captures accelerator results, tags line ends, buffers and streams them
//   Clk, RstIn                : clock, async active-low reset
//   cSum, cReady, newline     : accelerator result, ready level, force end-of-line pulse
//   clearOvf                  : clears sticky OVERFLOW
//   outData/outLast/outValid/outReady : host valid/ready stream
//   EMPTY, FULL, level        : FIFO status (output register not counted)
//   OVERFLOW                  : sticky, a capture was dropped
// Optional macro RESULT_SATURATE_EN: clamp signed cSum to the word range instead of truncating.
module conv_result_streamer
   import conv_result_streamer_pkg::*;
#(
   parameter int BIT_LENGTH = RESULT_BITS,
   parameter int DEPTH      = 8,
   parameter int LINE_LEN   = 4
) (
   input  logic                    Clk,
   input  logic                    RstIn,
   input  logic [2*BIT_LENGTH-1:0] cSum,
   input  logic                    cReady,
   input  logic                    newline,
   input  logic                    clearOvf,
   input  logic                    outReady,
   output logic [BIT_LENGTH-1:0]   outData,
   output logic                    outValid,
   output logic                    outLast,
   output logic                    EMPTY,
   output logic                    FULL,
   output logic                    OVERFLOW,
   output logic [$clog2(DEPTH):0]  level
);
   localparam int EW = entry_w(BIT_LENGTH);
   localparam int LW = LINE_LEN > 1 ? $clog2(LINE_LEN) : 1;
   state_t                state, state_nxt;
   logic                  cready_q, nl_pending, capture, last, push, pop;
   logic [LW-1:0]         line_cnt;
   logic [BIT_LENGTH-1:0] data;
   logic [EW-1:0]         head;
`ifdef RESULT_SATURATE_EN
   // the value fits when the bits above the result's sign bit are a pure sign extension
   logic fits;
   assign fits = (cSum[2*BIT_LENGTH-1:BIT_LENGTH-1] == '0) | (cSum[2*BIT_LENGTH-1:BIT_LENGTH-1] == '1);
   assign data = fits ? cSum[BIT_LENGTH-1:0]
               : cSum[2*BIT_LENGTH-1] ? BIT_LENGTH'(sat_min(BIT_LENGTH)) : BIT_LENGTH'(sat_max(BIT_LENGTH));
`else
   logic unused_hi;
   assign unused_hi = ^cSum[2*BIT_LENGTH-1:BIT_LENGTH];
   assign data      = cSum[BIT_LENGTH-1:0];
`endif
   assign capture  = cReady & ~cready_q;
   assign last     = (line_cnt == LW'(LINE_LEN - 1)) | nl_pending | newline;
   assign push     = capture & ~FULL;
   assign outValid = state == VALID;
   // refill the output register whenever it is free or being accepted this cycle
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      if (state == IDLE || outReady) begin
         pop       = ~EMPTY;
         state_nxt = EMPTY ? IDLE : VALID;
      end
   end
   always_ff @(posedge Clk or negedge RstIn)
      if (!RstIn) begin
         cready_q   <= 1'b0;
         line_cnt   <= '0;
         nl_pending <= 1'b0;
         OVERFLOW   <= 1'b0;
         state      <= IDLE;
         outData    <= '0;
         outLast    <= 1'b0;
      end else begin
         cready_q <= cReady;
         state    <= state_nxt;
         OVERFLOW <= (capture & FULL) | (OVERFLOW & ~clearOvf);
         if (push) begin
            line_cnt   <= last ? '0 : line_cnt + 1'b1;
            nl_pending <= 1'b0;
         end else if (newline & ~capture) begin
            nl_pending <= 1'b1;
         end
         if (pop) {outLast, outData} <= head;
      end
   result_sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
      .clk   (Clk),
      .rst_n (RstIn),
      .push  (push),
      .pop   (pop),
      .din   ({last, data}),
      .dout  (head),
      .empty (EMPTY),
      .full  (FULL),
      .level (level)
   );
endmodule

// File: doc/conv_result_streamer.md
Name: conv_result_streamer

Overview:
- Output-side counterpart to the convolution accelerator's input FIFO path.
- Captures each finished convolution sum when the accelerator's cReady rises and tags it with an end-of-line marker.
- Buffers results in a small synchronous FIFO and streams them to the external device over a valid/ready handshake.
- Sits between the accelerator top (cSum, cReady, newline) and the host read interface.

Parameters:
- BIT_LENGTH, 16, width of one result word delivered to the host (matches `bitLength).
- DEPTH, 8, FIFO entries (power of two, >= 2).
- LINE_LEN, 4, results per output line before an automatic end-of-line tag (>= 1).

Ports:
- Clk  in  1  single system clock; all logic on posedge.
- RstIn  in  1  asynchronous, active-low reset.
- cSum  in  2*BIT_LENGTH  full-width accumulator result.
- cReady  in  1  result-ready level from the accelerator; capture on its 0->1 transition.
- newline  in  1  one-cycle pulse: force end-of-line on the next captured result.
- clearOvf  in  1  clears the sticky overflow flag.
- outReady  in  1  host accepts the word presented this cycle.
- outData  out  BIT_LENGTH  result word.
- outValid  out  1  outData/outLast are valid.
- outLast  out  1  word is the last of its line.
- EMPTY  out  1  FIFO holds no entries (output stage excluded).
- FULL  out  1  FIFO holds DEPTH entries.
- OVERFLOW  out  1  sticky: a capture was dropped.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (RstIn=0, async): outValid=0, outData=0, outLast=0, EMPTY=1, FULL=0, OVERFLOW=0, level=0.
- Reset also clears pointers, line counter, newline-pending bit, the cReady history register, and returns the FSM to IDLE.
- Mid-stream reset discards all buffered data without completing any handshake.
- Capture:
  - capture = cReady & ~cReady_q, where cReady_q is cReady registered.
  - cReady held high produces exactly one capture.
- Word formation: data = cSum[BIT_LENGTH-1:0] (truncate; see Optional Feature).
- Line tagging:
  - last = (lineCnt == LINE_LEN-1) | nlPending | newline.
  - On an accepted capture, lineCnt <= last ? 0 : lineCnt+1, and nlPending clears.
  - newline with no capture in the same cycle sets nlPending.
  - newline coinciding with a capture tags that capture last.
- Write:
  - When capture & ~FULL, {last,data} is written at that edge.
  - When capture & FULL, the word is dropped, OVERFLOW <= 1, and lineCnt/nlPending are unchanged.
  - FULL is the registered occupancy; a same-cycle pop does not make room.
- OVERFLOW clears on clearOvf. If clearOvf and a drop occur in the same cycle, set wins.
- Output FSM:
  - IDLE: outValid=0. If ~EMPTY, pop the head into the output register and go to VALID.
  - VALID: outValid=1 and outData/outLast hold stable until outReady.
    - outReady & ~EMPTY: pop the next entry, stay in VALID (back-to-back, one word per cycle).
    - outReady & EMPTY: go to IDLE, outValid <= 0.
- Latency: capture edge k writes the FIFO at edge k; pop at edge k+1; outValid=1 after edge k+1.
- Simultaneous push and pop in the same cycle: level unchanged.
- Pointers wrap modulo DEPTH.
- level counts the FIFO only, so total storage is DEPTH+1 words.

Optional Feature:
- Macro: RESULT_SATURATE_EN.
- Defined: cSum is treated as signed two's complement and clamped to the signed BIT_LENGTH range.
  - Above 2^(BIT_LENGTH-1)-1 -> 0x7FFF (for 16 bits).
  - Below -2^(BIT_LENGTH-1) -> 0x8000.
- Undefined: plain truncation to the low BIT_LENGTH bits, identical to the existing finalsum slicing.

Decomposition:
- Shared package/header (alongside definitions.h) holds:
  - the result-entry layout {last, data} and its width constant;
  - FSM state encodings IDLE=0, VALID=1;
  - the saturation min/max constants derived from BIT_LENGTH.
- One sub-module: result_sync_fifo, a single-clock, parameterised, registered-occupancy FIFO with FULL/EMPTY/level. The top holds edge detect, line tagging, overflow and the output FSM.

Test Plan:
- Reset release, no activity -> outValid=0, EMPTY=1, level=0, OVERFLOW=0.
- cReady held high 5 cycles with cSum=0x0001_0042, outReady=1 -> exactly one word 0x0042, outValid rises 2 edges after the cReady rise.
- LINE_LEN=4, six capture pulses with values 1..6 and outReady=1 -> outLast=1 on word 4 only. Then newline pulse, one capture of 7 -> word 7 has outLast=1 and the next line restarts at count 0.
- outReady=0, 9 captures with DEPTH=8 -> first word held in the output stage, FULL=1, level=8, OVERFLOW=0. A 10th capture sets OVERFLOW=1 and is dropped. Draining then yields 9 words in order; clearOvf -> OVERFLOW=0.
- Backpressure: toggle outReady every cycle over 6 queued words -> each word stays stable until accepted, with no loss or duplication.
- RESULT_SATURATE_EN defined: cSum=0x0001_0000 -> 0x7FFF; cSum=0xFFFF_7000 -> 0x8000; cSum=0x0000_1234 -> 0x1234. Undefined: first case -> 0x0000.
